bcd_seg_scan: RTL and testbench
===============================

# bcd_seg_scan

Multiplexed 4-digit seven-segment display driver that sits directly downstream of `bin2bcd`. It captures the 17-bit packed BCD word on each `bcd_vld` pulse into a shadow register and continuously time-multiplexes the four digits onto one shared, active-low segment bus. Leading-zero blanking, an overflow indication and ghost-suppression blanking between digits are handled here, so the converter output can be wired straight to the board display.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Legal range is 2..65535.
- `clk`  input  1  system clock. All flops are clocked on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `bcd`  input  17  packed BCD word:
  - [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
  - [16] is the ten-thousands bit and acts as the overflow flag.
- `bcd_vld`  input  1  single-cycle qualifier for `bcd`.
- `seg`  output  8  active-low segments: [0]=a … [6]=g, [7]=dp. `dp` is always 1 (off).
- `dig_sel`  output  4  active-low digit enable. [0] is ones, [3] is thousands.
- `upd`  output  1  one-cycle pulse, registered, one cycle after a capture.

## Operation
- **Capture.** On a rising edge with `bcd_vld`=1, `shadow` ← `bcd` and `upd` is set for the next cycle. `bcd` is ignored when `bcd_vld`=0.
- **Divider.** `cnt` (16 bit) counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap, `idx` (2 bit) increments modulo 4 in the order 0→1→2→3→0.
  - `cnt` and `idx` free-run and are never reset by a capture.
- **Guard slot.** While `cnt`=0, the registered outputs are `dig_sel`=4'hF and `seg`=8'hFF. This prevents ghosting across a digit change.
- **Active slot.** While `cnt`≠0:
  - `dig_sel` = ~(4'b0001 << `idx`).
  - `seg` = encode(`shadow` nibble `idx`).
- **Encoding** (active-low, dp=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - A nibble of A..F is invalid and shows E = 86.
- **Overflow.** When `shadow[16]`=1, every digit shows a dash (BF), overriding both blanking and the E display.
- **Blank code.** A blanked digit keeps its `dig_sel` asserted and drives `seg`=FF.
- **Reset values.** `seg`=8'hFF, `dig_sel`=4'hF, `upd`=0, `shadow`=0, `cnt`=0, `idx`=0.

## Timing
- **Output register.** `seg` and `dig_sel` are registered from (`cnt`, `idx`, `shadow`), so they lag the counter state by one cycle.
- **Capture latency.** A capture at edge N updates `shadow` at N. If the digit being driven changes, `seg` shows it after edge N+1. `upd`=1 during the cycle after edge N.
- **Back-to-back `bcd_vld`.** Each cycle overwrites `shadow` (last value wins) and `upd` stays high.
- **Capture during a guard slot.** Outputs stay off; the new value appears on the first active cycle.
- **Slot structure.** One slot is SCAN_DIV cycles: 1 guard cycle plus SCAN_DIV-1 active cycles. A full refresh is 4·SCAN_DIV cycles.
- **Reset mid-scan.** All state clears asynchronously. The first cycle after reset release is a guard cycle for `idx` 0.

## Configuration
- Macro: `BCD_SEG_LZB_EN`.
- **Defined:** leading-zero blanking.
  - Thousands blanks if it is 0.
  - Hundreds blanks if it is 0 and thousands is blanked.
  - Tens blanks if it is 0 and hundreds is blanked.
  - Ones never blanks.
  - Invalid nibbles (A..F) never count as zero.
  - Blanking is evaluated combinationally from `shadow` and is overridden by overflow.
- **Undefined:** all four digits are always shown, e.g. 0042 is displayed as C0 C0 99 A4.

## Test plan
All scenarios use `SCAN_DIV`=4, so each slot is 1 guard cycle plus 3 active cycles.
- **Reset.** Hold `rst_n`=0 for 3 cycles mid-scan → `seg`=FF and `dig_sel`=F during reset and for the first cycle after release. Then, in the `idx`0 slot, `dig_sel`=E and `seg`=C0.
- **Capture 423.** Pulse `bcd_vld` with `bcd`=17'h00423 → `upd` pulses once, and successive active slots show:
  - `dig_sel` E with `seg` B0,
  - D with A4,
  - B with 99,
  - 7 with FF when `BCD_SEG_LZB_EN` is defined, or C0 when it is not.
- **Guard cycle.** Check every slot boundary → exactly one cycle with `dig_sel`=F between consecutive digit enables, and no cycle with two `dig_sel` bits low.
- **Overflow and invalid.** `bcd`=17'h10000 → all four digits show BF. Then `bcd`=17'h0000C → ones shows 86, and the others are FF (LZB) or C0 (no LZB).
- **Back-to-back update.** `bcd_vld` high for 2 cycles with 17'h01234 then 17'h01999 → `shadow` ends at 1999, giving `seg` 90 / 90 / 90 / F9 for the ones / tens / hundreds / thousands slots, and `upd` is high for 2 cycles.
- **Zero with LZB.** `bcd`=17'h00000 with `BCD_SEG_LZB_EN` → only the ones digit shows C0; the other three slots show FF.

Source files
------------

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: captures a packed BCD word and scans it onto a 4-digit active-low seven-segment display.
// Optional leading-zero blanking is compiled in when BCD_SEG_LZB_EN is defined.
module bcd_seg_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] bcd,
    input  logic        bcd_vld,
    output logic [7:0]  seg,
    output logic [3:0]  dig_sel,
    output logic        upd
);
    localparam logic [15:0] LP_CNT_LAST = 16'(SCAN_DIV - 1);

    logic [16:0] r_shadow;
    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic        r_upd;
    logic [7:0]  r_seg;
    logic [3:0]  r_dig;

    logic [3:0]  w_nib;
    logic [3:1]  w_zero;
    logic [3:0]  w_blank;
    logic [7:0]  w_seg_nxt;
    logic [3:0]  w_dig_nxt;

    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'h86;
        endcase
        return s;
    endfunction

    always_comb begin
        w_nib     = r_shadow[{r_idx, 2'b00} +: 4];
        w_zero[3] = (r_shadow[15:12] == 4'd0);
        w_zero[2] = (r_shadow[11:8]  == 4'd0);
        w_zero[1] = (r_shadow[7:4]   == 4'd0);
    end

`ifdef BCD_SEG_LZB_EN
    // A digit blanks only when it and every more significant digit are zero.
    assign w_blank = {w_zero[3],
                      w_zero[3] & w_zero[2],
                      w_zero[3] & w_zero[2] & w_zero[1],
                      1'b0};
`else
    assign w_blank = {3'b000, &{1'b0, w_zero}};
`endif

    always_comb begin
        w_dig_nxt = 4'hF;
        w_seg_nxt = 8'hFF;
        if (r_cnt != 16'd0) begin
            w_dig_nxt = ~(4'b0001 << r_idx);
            if (r_shadow[16])
                w_seg_nxt = 8'hBF;
            else if (w_blank[r_idx])
                w_seg_nxt = 8'hFF;
            else
                w_seg_nxt = enc(w_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_upd    <= 1'b0;
            r_seg    <= 8'hFF;
            r_dig    <= 4'hF;
        end else begin
            r_upd <= bcd_vld;
            if (bcd_vld)
                r_shadow <= bcd;
            if (r_cnt == LP_CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_seg <= w_seg_nxt;
            r_dig <= w_dig_nxt;
        end
    end

    assign seg     = r_seg;
    assign dig_sel = r_dig;
    assign upd     = r_upd;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan with SCAN_DIV=4; a cycle model pushes expected outputs at each
// rising edge and the checker pops them on the falling edge, plus directed per-slot checks.
module tb_bcd_seg_scan;
    localparam int SCAN_DIV = 4;
    localparam logic [7:0] ENC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [16:0] bcd = '0;
    logic        bcd_vld = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic        upd;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       upd;
    } exp_t;

    exp_t        q_exp [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          upd_cnt = 0;
    int          m_cnt;
    logic [1:0]  m_idx;
    logic [16:0] m_shadow;
    logic [3:0]  prev_dig = 4'hF;

    bcd_seg_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bcd     (bcd),
        .bcd_vld (bcd_vld),
        .seg     (seg),
        .dig_sel (dig_sel),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_seg(input logic [16:0] sh, input logic [1:0] ix);
        int         i;
        logic [3:0] nib;
        bit         lead;
        i = int'(ix);
        if (sh[16]) return 8'hBF;
        nib = sh[i*4 +: 4];
        lead = 1'b1;
        for (int d = 3; d > i; d--)
            if (sh[d*4 +: 4] != 4'd0) lead = 1'b0;
`ifdef BCD_SEG_LZB_EN
        if (i != 0 && lead && nib == 4'd0) return 8'hFF;
`endif
        return ENC[nib];
    endfunction

    // Reference model: expected registered outputs for the cycle after this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_idx    <= 2'd0;
            m_shadow <= '0;
            q_exp.delete();
        end else begin
            exp_t e;
            e.upd = bcd_vld;
            if (m_cnt == 0) begin
                e.dig = 4'hF;
                e.seg = 8'hFF;
            end else begin
                e.dig = ~(4'b0001 << m_idx);
                e.seg = model_seg(m_shadow, m_idx);
            end
            q_exp.push_back(e);
            if (bcd_vld) m_shadow <= bcd;
            if (m_cnt == SCAN_DIV - 1) begin
                m_cnt <= 0;
                m_idx <= m_idx + 2'd1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_seg", 32'(seg), 32'hFF);
            chk("rst_dig", 32'(dig_sel), 32'hF);
            chk("rst_upd", 32'(upd), 32'h0);
        end else if (q_exp.size() == 0) begin
            chk("sb_empty", 32'(q_exp.size()), 32'd1);
        end else begin
            exp_t e;
            e = q_exp.pop_front();
            chk("sb_seg", 32'(seg), 32'(e.seg));
            chk("sb_dig", 32'(dig_sel), 32'(e.dig));
            chk("sb_upd", 32'(upd), 32'(e.upd));
            if (upd) upd_cnt++;
        end
        chk("onehot", 32'($countones(~dig_sel) <= 1), 32'd1);
        if (dig_sel != 4'hF && prev_dig != 4'hF && dig_sel != prev_dig)
            chk("guard_gap", 32'(prev_dig), 32'hF);
        prev_dig = dig_sel;
    end

    task automatic wait_dig(input logic [3:0] target, input logic [7:0] exp_seg, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (dig_sel == target) hit = 1'b1;
        end
        if (!hit) chk({tag, "_timeout"}, 32'(dig_sel), 32'(target));
        else      chk(tag, 32'(seg), 32'(exp_seg));
    endtask

    task automatic drive(input logic [16:0] val);
        @(posedge clk);
        #1;
        bcd_vld = 1'b1;
        bcd     = val;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bcd_vld = 1'b0;
        bcd     = 17'h1FFFF;
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (ncyc) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] lz;
        int         u0;
`ifdef BCD_SEG_LZB_EN
        lz = 8'hFF;
`else
        lz = 8'hC0;
`endif
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);

        // Reset in the middle of a scan.
        do_reset(3);
        @(negedge clk);
        chk("post_rst_dig", 32'(dig_sel), 32'hF);
        chk("post_rst_seg", 32'(seg), 32'hFF);
        wait_dig(4'hE, 8'hC0, "rst_idx0");

        // Single capture of 423.
        u0 = upd_cnt;
        drive(17'h00423);
        idle();
        repeat (2) @(negedge clk);
        chk("upd_once", 32'(upd_cnt - u0), 32'd1);
        wait_dig(4'hE, 8'hB0, "d423_ones");
        wait_dig(4'hD, 8'hA4, "d423_tens");
        wait_dig(4'hB, 8'h99, "d423_hund");
        wait_dig(4'h7, lz,    "d423_thou");

        // Overflow then invalid nibble.
        drive(17'h10000);
        idle();
        repeat (2) @(negedge clk);
        wait_dig(4'hE, 8'hBF, "ovf_ones");
        wait_dig(4'hD, 8'hBF, "ovf_tens");
        wait_dig(4'hB, 8'hBF, "ovf_hund");
        wait_dig(4'h7, 8'hBF, "ovf_thou");
        drive(17'h0000C);
        idle();
        repeat (2) @(negedge clk);
        wait_dig(4'hE, 8'h86, "inv_ones");
        wait_dig(4'hD, lz,    "inv_tens");
        wait_dig(4'hB, lz,    "inv_hund");
        wait_dig(4'h7, lz,    "inv_thou");

        // Back-to-back captures: last value wins.
        u0 = upd_cnt;
        drive(17'h01234);
        drive(17'h01999);
        idle();
        repeat (3) @(negedge clk);
        chk("upd_twice", 32'(upd_cnt - u0), 32'd2);
        wait_dig(4'hE, 8'h90, "b2b_ones");
        wait_dig(4'hD, 8'h90, "b2b_tens");
        wait_dig(4'hB, 8'h90, "b2b_hund");
        wait_dig(4'h7, 8'hF9, "b2b_thou");

        // All-zero value.
        drive(17'h00000);
        idle();
        repeat (2) @(negedge clk);
        wait_dig(4'hE, 8'hC0, "zero_ones");
        wait_dig(4'hD, lz,    "zero_tens");
        wait_dig(4'hB, lz,    "zero_hund");
        wait_dig(4'h7, lz,    "zero_thou");

        // Capture landing on a guard cycle (cnt wraps every 4 cycles).
        drive(17'h00987);
        idle();
        repeat (2) @(negedge clk);
        wait_dig(4'hE, 8'hF8, "late_ones");
        wait_dig(4'hB, 8'h90, "late_hund");

        repeat (8) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
